// File: rtl/axi_err_slv.sv
// axi_err_slv: terminal AXI4 subordinate for unmapped address regions.
// Every accepted transaction is completed with a fixed error response so
// stray accesses never hang the interconnect.
//
// Ports:
//   clk_i       in   clock, all state updates on the rising edge
//   rst_ni      in   asynchronous active-low reset
//   slv_req_i   in   AXI request struct (aw, w, ar + valids, b_ready, r_ready)
//   slv_resp_o  out  AXI response struct (b, r + valids, channel readies)
//
// Handshake rule (all channels): a transfer happens on a rising edge where
// valid && ready are both high. b_valid/r_valid are never retracted and their
// payload stays stable until that transfer.

package axi_err_slv_pkg;

  localparam int unsigned IdW   = 4;
  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 64;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [AddrW-1:0] addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic [5:0]       atop;
  } aw_chan_t;

  typedef struct packed {
    logic [DataW-1:0]   data;
    logic [DataW/8-1:0] strb;
    logic               last;
  } w_chan_t;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [AddrW-1:0] addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
  } ar_chan_t;

  typedef struct packed {
    logic [IdW-1:0] id;
    logic [1:0]     resp;
  } b_chan_t;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [DataW-1:0] data;
    logic [1:0]       resp;
    logic             last;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } axi_resp_t;

endpackage

module axi_err_slv #(
  parameter int unsigned IdWidth  = 4,
  parameter int unsigned MaxTrans = 2,
  parameter logic [1:0]  Resp     = 2'b11,
  parameter logic [63:0] RespData = 64'hBADCAB1E_BADCAB1E,
  parameter type axi_req_t  = axi_err_slv_pkg::axi_req_t,
  parameter type axi_resp_t = axi_err_slv_pkg::axi_resp_t
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  axi_req_t  slv_req_i,
  output axi_resp_t slv_resp_o
);

  localparam int unsigned PtrW      = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
  localparam int unsigned CntW      = $clog2(MaxTrans + 1);
  localparam int unsigned DataWidth = $bits(slv_resp_o.r.data);
  localparam logic [PtrW-1:0]      LastPtr  = PtrW'(MaxTrans - 1);
  localparam logic [CntW-1:0]      FullCnt  = CntW'(MaxTrans);
  localparam logic [DataWidth-1:0] RespDataT = RespData[DataWidth-1:0];

  typedef enum logic {
    WR_DATA = 1'b0,
    WR_RESP = 1'b1
  } wr_state_e;

  // ---------------------------------------------------------------------------
  // AW FIFO: stores the write ID of each accepted AW.
  // ---------------------------------------------------------------------------
  logic [IdWidth-1:0] r_aw_mem [MaxTrans];
  logic [PtrW-1:0]    r_aw_wptr;
  logic [PtrW-1:0]    r_aw_rptr;
  logic [CntW-1:0]    r_aw_cnt;
  logic               w_aw_full;
  logic               w_aw_empty;
  logic               w_aw_push;
  logic               w_aw_pop;
  logic [IdWidth-1:0] w_aw_head;

  // Full is judged on the registered count only, so a pop in the same cycle
  // does not reopen aw_ready (no push-on-pop bypass).
  assign w_aw_full  = (r_aw_cnt == FullCnt);
  assign w_aw_empty = (r_aw_cnt == '0);
  assign w_aw_push  = slv_req_i.aw_valid && !w_aw_full;
  assign w_aw_head  = r_aw_mem[r_aw_rptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_aw_wptr <= '0;
      r_aw_rptr <= '0;
      r_aw_cnt  <= '0;
    end else begin
      if (w_aw_push) begin
        r_aw_wptr <= (r_aw_wptr == LastPtr) ? '0 : r_aw_wptr + 1'b1;
      end
      if (w_aw_pop) begin
        r_aw_rptr <= (r_aw_rptr == LastPtr) ? '0 : r_aw_rptr + 1'b1;
      end
      case ({w_aw_push, w_aw_pop})
        2'b10:   r_aw_cnt <= r_aw_cnt + 1'b1;
        2'b01:   r_aw_cnt <= r_aw_cnt - 1'b1;
        default: r_aw_cnt <= r_aw_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_aw_push) begin
      r_aw_mem[r_aw_wptr] <= IdWidth'(slv_req_i.aw.id);
    end
  end

  // ---------------------------------------------------------------------------
  // AR FIFO: stores {id, len} of each accepted AR.
  // ---------------------------------------------------------------------------
  logic [IdWidth+7:0] r_ar_mem [MaxTrans];
  logic [PtrW-1:0]    r_ar_wptr;
  logic [PtrW-1:0]    r_ar_rptr;
  logic [CntW-1:0]    r_ar_cnt;
  logic               w_ar_full;
  logic               w_ar_empty;
  logic               w_ar_push;
  logic               w_ar_pop;
  logic [IdWidth+7:0] w_ar_head;

  assign w_ar_full  = (r_ar_cnt == FullCnt);
  assign w_ar_empty = (r_ar_cnt == '0);
  assign w_ar_push  = slv_req_i.ar_valid && !w_ar_full;
  assign w_ar_head  = r_ar_mem[r_ar_rptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ar_wptr <= '0;
      r_ar_rptr <= '0;
      r_ar_cnt  <= '0;
    end else begin
      if (w_ar_push) begin
        r_ar_wptr <= (r_ar_wptr == LastPtr) ? '0 : r_ar_wptr + 1'b1;
      end
      if (w_ar_pop) begin
        r_ar_rptr <= (r_ar_rptr == LastPtr) ? '0 : r_ar_rptr + 1'b1;
      end
      case ({w_ar_push, w_ar_pop})
        2'b10:   r_ar_cnt <= r_ar_cnt + 1'b1;
        2'b01:   r_ar_cnt <= r_ar_cnt - 1'b1;
        default: r_ar_cnt <= r_ar_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_ar_push) begin
      r_ar_mem[r_ar_wptr] <= {IdWidth'(slv_req_i.ar.id), slv_req_i.ar.len};
    end
  end

  // ---------------------------------------------------------------------------
  // Write path: drain W beats of the head AW, then return one B.
  // ---------------------------------------------------------------------------
  wr_state_e r_wr_state;
  wr_state_e w_wr_state_nxt;
  logic      w_w_ready;
  logic      w_b_valid;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_state <= WR_DATA;
    end else begin
      r_wr_state <= w_wr_state_nxt;
    end
  end

  always_comb begin
    w_wr_state_nxt = r_wr_state;
    w_w_ready      = 1'b0;
    w_b_valid      = 1'b0;
    w_aw_pop       = 1'b0;
    case (r_wr_state)
      WR_DATA: begin
        // W is only taken once its AW is known, so data never runs ahead.
        w_w_ready = !w_aw_empty;
        if (slv_req_i.w_valid && w_w_ready && slv_req_i.w.last) begin
          w_wr_state_nxt = WR_RESP;
        end
      end
      WR_RESP: begin
        w_b_valid = 1'b1;
        if (slv_req_i.b_ready) begin
          w_aw_pop       = 1'b1;
          w_wr_state_nxt = WR_DATA;
        end
      end
      default: w_wr_state_nxt = WR_DATA;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read path: len+1 beats per AR, counted by r_rcnt. The counter clears on
  // the last beat, so a len of 255 never needs a ninth bit.
  // ---------------------------------------------------------------------------
  logic [7:0] r_rcnt;
  logic       w_r_valid;
  logic       w_r_last;
  logic       w_r_hs;

  assign w_r_valid = !w_ar_empty;
  assign w_r_last  = (r_rcnt == w_ar_head[7:0]);
  assign w_r_hs    = w_r_valid && slv_req_i.r_ready;
  assign w_ar_pop  = w_r_hs && w_r_last;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rcnt <= '0;
    end else if (w_r_hs) begin
      r_rcnt <= w_r_last ? 8'd0 : r_rcnt + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Response assembly; every field not set here stays 0.
  // ---------------------------------------------------------------------------
  always_comb begin
    slv_resp_o          = '0;
    slv_resp_o.aw_ready = !w_aw_full;
    slv_resp_o.ar_ready = !w_ar_full;
    slv_resp_o.w_ready  = w_w_ready;
    slv_resp_o.b_valid  = w_b_valid;
    slv_resp_o.b.id     = w_aw_head;
    slv_resp_o.b.resp   = Resp;
    slv_resp_o.r_valid  = w_r_valid;
    slv_resp_o.r.id     = w_ar_head[IdWidth+7:8];
    slv_resp_o.r.data   = RespDataT;
    slv_resp_o.r.resp   = Resp;
    slv_resp_o.r.last   = w_r_last;
  end

  // Address, data, strobe, atop and size fields are intentionally ignored.
  logic w_unused;
  assign w_unused = ^slv_req_i;

endmodule

// File: tb/tb_axi_err_slv.sv
module tb_axi_err_slv;
  import axi_err_slv_pkg::*;

  localparam logic [63:0] RDATA = 64'hBADCAB1E_BADCAB1E;

  logic      clk = 1'b0;
  logic      rst_n;
  axi_req_t  req;
  axi_resp_t resp;
  int        n_vec = 0;
  int        n_err = 0;

  axi_err_slv dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .slv_req_i  (req),
    .slv_resp_o (resp)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard of expected B ids for the back-to-back AW test
  logic [3:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Send one last W beat, then wait for and accept one B.
  task automatic write_b(input logic [3:0] exp_id);
    req.w_valid = 1'b1;
    req.w.last  = 1'b1;
    req.b_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 20 && resp.w_ready !== 1'b1; i++) @(negedge clk);
    chk("wb_w_ready", resp.w_ready, 1);
    next_cycle();
    req.w_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 20 && resp.b_valid !== 1'b1; i++) @(negedge clk);
    chk("wb_b_valid", resp.b_valid, 1);
    chk("wb_b_id", resp.b.id, exp_id);
    chk("wb_b_resp", resp.b.resp, 2'b11);
    req.b_ready = 1'b1;
    next_cycle();
    req.b_ready = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_id [2];
    int         exp_len [2];
    int         idx;
    int         beat;
    logic       prev_stall;
    logic [3:0] prev_id;
    logic       prev_last;

    req   = '0;
    rst_n = 1'b0;

    // ---- reset values
    #12;
    chk("rst_aw_ready", resp.aw_ready, 1);
    chk("rst_ar_ready", resp.ar_ready, 1);
    chk("rst_w_ready", resp.w_ready, 0);
    chk("rst_b_valid", resp.b_valid, 0);
    chk("rst_r_valid", resp.r_valid, 0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // ---- single write: AW t, W t+1, B t+2
    req.aw.id    = 4'd3;
    req.aw_valid = 1'b1;
    @(negedge clk);
    chk("t1_aw_ready", resp.aw_ready, 1);
    next_cycle();
    req.aw_valid = 1'b0;
    req.w_valid  = 1'b1;
    req.w.last   = 1'b1;
    req.b_ready  = 1'b1;
    @(negedge clk);
    chk("t1_w_ready", resp.w_ready, 1);
    chk("t1_b_early", resp.b_valid, 0);
    next_cycle();
    req.w_valid = 1'b0;
    @(negedge clk);
    chk("t1_b_valid", resp.b_valid, 1);
    chk("t1_b_id", resp.b.id, 4'd3);
    chk("t1_b_resp", resp.b.resp, 2'b11);
    next_cycle();
    @(negedge clk);
    chk("t1_one_b_a", resp.b_valid, 0);
    next_cycle();
    @(negedge clk);
    chk("t1_one_b_b", resp.b_valid, 0);
    req.b_ready = 1'b0;
    next_cycle();

    // ---- read id=5 len=3 with r_ready held high
    req.ar.id    = 4'd5;
    req.ar.len   = 8'd3;
    req.ar_valid = 1'b1;
    req.r_ready  = 1'b1;
    @(negedge clk);
    chk("t2_ar_ready", resp.ar_ready, 1);
    next_cycle();
    req.ar_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      chk("t2_r_valid", resp.r_valid, 1);
      chk("t2_r_id", resp.r.id, 4'd5);
      chk("t2_r_data", resp.r.data, RDATA);
      chk("t2_r_resp", resp.r.resp, 2'b11);
      chk("t2_r_last", resp.r.last, (b == 3) ? 1 : 0);
      next_cycle();
    end
    @(negedge clk);
    chk("t2_r_done", resp.r_valid, 0);
    chk("t2_ar_ready_back", resp.ar_ready, 1);
    req.r_ready = 1'b0;
    next_cycle();

    // ---- three AWs back-to-back with MaxTrans=2
    for (int k = 1; k <= 2; k++) begin
      req.aw.id    = 4'(k);
      req.aw_valid = 1'b1;
      @(negedge clk);
      chk("t3_aw_accept", resp.aw_ready, 1);
      exp_q.push_back(4'(k));
      next_cycle();
    end
    req.aw.id = 4'd3;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3_aw_full", resp.aw_ready, 0);
      next_cycle();
    end
    req.w_valid = 1'b1;
    req.w.last  = 1'b1;
    req.b_ready = 1'b1;
    @(negedge clk);
    chk("t3_w_ready", resp.w_ready, 1);
    next_cycle();
    req.w_valid = 1'b0;
    @(negedge clk);
    chk("t3_b_valid", resp.b_valid, 1);
    chk("t3_b_id_first", resp.b.id, exp_q.pop_front());
    chk("t3_no_bypass", resp.aw_ready, 0);
    next_cycle();
    req.b_ready = 1'b0;
    @(negedge clk);
    chk("t3_aw_reopen", resp.aw_ready, 1);
    exp_q.push_back(4'd3);
    next_cycle();
    req.aw_valid = 1'b0;
    while (exp_q.size() > 0) write_b(exp_q.pop_front());

    // ---- W before AW is stalled; non-last beats are drained
    req.w_valid = 1'b1;
    req.w.last  = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t5_w_stall", resp.w_ready, 0);
      next_cycle();
    end
    req.aw.id    = 4'd9;
    req.aw_valid = 1'b1;
    @(negedge clk);
    chk("t5_aw_ready", resp.aw_ready, 1);
    chk("t5_w_still_stall", resp.w_ready, 0);
    next_cycle();
    req.aw_valid = 1'b0;
    @(negedge clk);
    chk("t5_w_open", resp.w_ready, 1);
    next_cycle();
    req.w.last = 1'b1;
    @(negedge clk);
    chk("t5_w_open2", resp.w_ready, 1);
    chk("t5_no_b_yet", resp.b_valid, 0);
    next_cycle();
    req.w_valid = 1'b0;
    req.b_ready = 1'b1;
    @(negedge clk);
    chk("t5_b_valid", resp.b_valid, 1);
    chk("t5_b_id", resp.b.id, 4'd9);
    next_cycle();
    req.b_ready = 1'b0;
    @(negedge clk);
    chk("t5_b_done", resp.b_valid, 0);
    next_cycle();

    // ---- AR len=0 then len=255 with random r_ready stalls
    exp_id[0] = 4'd6;  exp_len[0] = 0;
    exp_id[1] = 4'd7;  exp_len[1] = 255;
    for (int k = 0; k < 2; k++) begin
      req.ar.id    = exp_id[k];
      req.ar.len   = 8'(exp_len[k]);
      req.ar_valid = 1'b1;
      @(negedge clk);
      chk("t4_ar_ready", resp.ar_ready, 1);
      next_cycle();
    end
    req.ar_valid = 1'b0;
    idx        = 0;
    beat       = 0;
    prev_stall = 1'b0;
    prev_id    = '0;
    prev_last  = 1'b0;
    req.r_ready = ($urandom_range(0, 3) != 0);
    for (int c = 0; c < 3000 && idx < 2; c++) begin
      @(negedge clk);
      if (prev_stall) begin
        chk("t4_hold_valid", resp.r_valid, 1);
        chk("t4_hold_id", resp.r.id, prev_id);
        chk("t4_hold_last", resp.r.last, prev_last);
      end
      if (resp.r_valid && req.r_ready) begin
        chk("t4_r_id", resp.r.id, exp_id[idx]);
        chk("t4_r_last", resp.r.last, (beat == exp_len[idx]) ? 1 : 0);
        chk("t4_r_data", resp.r.data, RDATA);
        if (beat == exp_len[idx]) begin
          idx++;
          beat = 0;
        end else begin
          beat++;
        end
      end
      prev_stall = resp.r_valid && !req.r_ready;
      prev_id    = resp.r.id;
      prev_last  = resp.r.last;
      next_cycle();
      req.r_ready = ($urandom_range(0, 3) != 0);
    end
    chk("t4_bursts_done", idx, 2);
    req.r_ready = 1'b0;
    @(negedge clk);
    chk("t4_r_idle", resp.r_valid, 0);
    next_cycle();

    // ---- reset mid-burst with a pending B
    req.ar.id    = 4'd2;
    req.ar.len   = 8'd15;
    req.ar_valid = 1'b1;
    req.aw.id    = 4'd4;
    req.aw_valid = 1'b1;
    next_cycle();
    req.ar_valid = 1'b0;
    req.aw_valid = 1'b0;
    req.w_valid  = 1'b1;
    req.w.last   = 1'b1;
    next_cycle();
    req.w_valid = 1'b0;
    req.r_ready = 1'b1;
    repeat (5) next_cycle();
    @(negedge clk);
    chk("t6_pre_r_valid", resp.r_valid, 1);
    chk("t6_pre_b_valid", resp.b_valid, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_r_valid", resp.r_valid, 0);
    chk("t6_rst_b_valid", resp.b_valid, 0);
    chk("t6_rst_aw_ready", resp.aw_ready, 1);
    chk("t6_rst_ar_ready", resp.ar_ready, 1);
    next_cycle();
    rst_n = 1'b1;
    req.b_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t6_no_stale_r", resp.r_valid, 0);
      chk("t6_no_stale_b", resp.b_valid, 0);
      next_cycle();
    end
    req.b_ready  = 1'b0;
    req.ar.id    = 4'd1;
    req.ar.len   = 8'd0;
    req.ar_valid = 1'b1;
    @(negedge clk);
    chk("t6_ar_ready", resp.ar_ready, 1);
    next_cycle();
    req.ar_valid = 1'b0;
    @(negedge clk);
    chk("t6_r_valid", resp.r_valid, 1);
    chk("t6_r_id", resp.r.id, 4'd1);
    chk("t6_r_last", resp.r.last, 1);
    next_cycle();
    @(negedge clk);
    chk("t6_r_done", resp.r_valid, 0);
    req.r_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
